uart_reg_cmd: RTL and testbench
===============================

Name: uart_reg_cmd

Overview:
- UART command endpoint at 115200 baud, 8N1, running from the 12 MHz board clock.
- Receives ASCII "set" commands of the form 'S' + channel digit + two hex digits, and stores the byte in one of four 8-bit channel registers.
- Acknowledges each command on TX with an ASCII reply.
- Sits between the host serial link and downstream logic that consumes the channel registers; the registers are internal and observable only through replies.

Parameters:
- CLK_HZ, 12000000, system clock frequency.
- BAUD, 115200, serial bit rate. Bit period = CLK_HZ/BAUD, truncated (104 clocks).
- NUM_CH, 4, number of 8-bit channel registers. Valid channel digits are '0' to NUM_CH-1.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- RX   in  1  serial input, 8N1, LSB first.
- TX   out 1  serial output, 8N1, LSB first; idles high.

Behaviour:
- Reset: TX=1; all channel registers=0x00; receiver, parser and transmitter return to idle. A reset mid-frame or mid-reply aborts the frame or reply; TX returns high on the next clock.
- RX synchronisation: RX passes through a 2-flop synchroniser.
- Start detection: in receiver idle, a sampled low level starts a frame. RX is not required to have been high first, so a frame whose start bit begins at time 0 is accepted.
- Start confirmation: re-check RX at half a bit; if high, return to idle.
- Data sampling: sample the 8 data bits at bit centres, LSB first, then the stop bit.
- Framing errors: a stop bit of 0 is a framing error and the byte is discarded.
- Back-to-back frames: the receiver returns to idle right after the stop-bit sample, so a start bit directly following a single stop bit is caught.
- Parser states: IDLE, CH, HI, LO.
  - IDLE: 'S' goes to CH; any other byte is ignored.
  - CH: a digit '0' to NUM_CH-1 is latched, go to HI; any other byte gives an error reply.
  - HI: a hex digit (0-9, A-F, a-f) is latched, go to LO; otherwise error reply.
  - LO: a hex digit writes {hi,lo} to the selected register and gives an OK reply; otherwise error reply. Parser returns to IDLE in all cases.
- OK reply: 'S', the channel digit, two uppercase hex digits of the new register value, CR, LF. Six bytes, e.g. "S0F7\r\n".
- Error reply: 'E', CR, LF.
- Reply latency: the first start bit begins within 2 clocks of the stop-bit sample of the last command byte.
- Reply framing: bytes are sent back to back with one stop bit each, 104 clocks per bit.
- Bytes during a reply: bytes received while a reply is being sent are still parsed. A command that completes during an active reply updates its register, but its reply is dropped; there is no queue.

Optional Feature:
- Macro READBACK_EN.
- Defined: in IDLE, 'R' goes to a read-channel state. A valid channel digit replies 'S', the digit, two hex digits of the current value, CR, LF, without modifying the register. An invalid digit gives the error reply.
- Undefined: 'R' is ignored like any other non-'S' byte in IDLE.

Test Plan:
- After reset, TX=1 for 10 bit times; send "S0F7" back to back -> ch0=0xF7 and TX carries "S0F7\r\n" at 115200 baud.
- Send "S259" -> ch2=0x59 and reply "S259\r\n"; then "S114" -> ch1=0x14 and reply "S114\r\n"; then "S350" -> ch3=0x50 and reply "S350\r\n". Other channels keep their values.
- Send "S4AA" -> reply "E\r\n" with no register change. Send "S0G1" -> reply "E\r\n" after the 'G' byte, and the trailing '1' is ignored.
- Send "s0ab": the leading 's' is ignored. Then "S0ab" -> ch0=0xAB and reply "S0AB\r\n".
- Send a frame with stop bit 0 containing 'S', then "S1" + "20" -> only the second 'S' is parsed, ch1=0x20, reply "S120\r\n".
- Assert RST mid-reply -> TX high the next clock and all registers 0x00. With READBACK_EN, "R1" -> reply "S100\r\n".

Source files
------------

// File: rtl/uart_reg_cmd.sv
// uart_reg_cmd -- UART command endpoint driving four 8-bit channel registers.
//
// Receives ASCII set commands 'S' <channel digit> <hex hi> <hex lo> over an
// 8N1 serial link and stores the byte in the selected channel register.
// Every command is answered on TX: "S<ch><HH>\r\n" on success, "E\r\n" on a
// malformed command. Replies are not queued; a command that completes while
// a reply is still going out updates its register silently.
//
// Optional feature: define READBACK_EN to add 'R' <channel digit>, which
// replies with the current register value without modifying it.
//
// Parameters:
//   CLK_HZ  system clock frequency in Hz
//   BAUD    serial bit rate; bit period is CLK_HZ/BAUD clocks (truncated)
//   NUM_CH  number of channel registers (digits '0'..NUM_CH-1)
//
// Ports:
//   CLK  in   system clock, rising edge
//   RST  in   synchronous active-high reset
//   RX   in   serial input, 8N1, LSB first (asynchronous to CLK)
//   TX   out  serial output, 8N1, LSB first, idles high

module uart_reg_cmd #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200,
  parameter int NUM_CH = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic RX,
  output logic TX
);

  localparam int BIT_CLKS  = CLK_HZ / BAUD;
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam int CNT_W     = $clog2(BIT_CLKS);
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF_CLKS - 1);

  localparam logic [7:0] CH_FIRST = 8'h30;
  localparam logic [7:0] CH_LAST  = 8'(8'h30 + NUM_CH - 1);
  localparam logic [7:0] ASC_S    = 8'h53;
  localparam logic [7:0] ASC_E    = 8'h45;
  localparam logic [7:0] ASC_CR   = 8'h0D;
  localparam logic [7:0] ASC_LF   = 8'h0A;
`ifdef READBACK_EN
  localparam logic [7:0] ASC_R    = 8'h52;
`endif

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  localparam logic [2:0] P_IDLE = 3'd0;
  localparam logic [2:0] P_CH   = 3'd1;
  localparam logic [2:0] P_HI   = 3'd2;
  localparam logic [2:0] P_LO   = 3'd3;
`ifdef READBACK_EN
  localparam logic [2:0] P_RD   = 3'd4;
`endif

  function automatic logic is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) ||
           (b >= 8'h41 && b <= 8'h46) ||
           (b >= 8'h61 && b <= 8'h66);
  endfunction

  // Letters A-F/a-f all carry 1..6 in the low nibble, so +9 maps them to 10..15.
  function automatic logic [3:0] hex_val(input logic [7:0] b);
    if (b <= 8'h39) return b[3:0];
    return 4'(b[3:0] + 4'd9);
  endfunction

  function automatic logic [7:0] hex_chr(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'b0, n};
    return 8'h37 + {4'b0, n};
  endfunction

  function automatic logic is_chan(input logic [7:0] b);
    return (b >= CH_FIRST) && (b <= CH_LAST);
  endfunction

  function automatic logic [CH_W-1:0] chan_idx(input logic [7:0] b);
    logic [7:0] d;
    d = b - CH_FIRST;
    return d[CH_W-1:0];
  endfunction

  function automatic logic [7:0] chan_chr(input logic [CH_W-1:0] idx);
    logic [7:0] d;
    d = '0;
    d[CH_W-1:0] = idx;
    return CH_FIRST + d;
  endfunction

  function automatic logic [9:0] frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  logic             rx_s1, rx_s2;
  logic [1:0]       rx_st;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bitn;
  logic [7:0]       rx_data;
  logic             rx_vld;
  logic             rx_tick;

  logic [2:0]       p_st, p_nxt;
  logic [CH_W-1:0]  ch_sel;
  logic [3:0]       hi_nib;
  logic [7:0]       chreg [NUM_CH];

  logic             wr_en, rep_ok, rep_err, rep_go;
  logic [7:0]       wr_val, rep_chr, rep_val;
  logic             rep_req;
  logic [7:0]       rep_b [6];
  logic [2:0]       rep_len;

  logic             tx_busy;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_bitn;
  logic [2:0]       tx_idx;
  logic [9:0]       tx_sh;
  logic             tx_last;

  assign rx_tick = (rx_cnt == '0);

  // ---- Receiver: synchroniser, start check at half bit, samples at bit centres
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_st   <= R_IDLE;
      rx_cnt  <= '0;
      rx_bitn <= '0;
      rx_vld  <= 1'b0;
    end else begin
      rx_s1  <= RX;
      rx_s2  <= rx_s1;
      rx_vld <= 1'b0;
      case (rx_st)
        // Any low level starts a frame; no preceding high is required.
        R_IDLE: begin
          if (!rx_s2) begin
            rx_st  <= R_START;
            rx_cnt <= HALF_M1;
          end
        end
        R_START: begin
          if (rx_tick) begin
            if (!rx_s2) begin
              rx_st   <= R_DATA;
              rx_cnt  <= BIT_M1;
              rx_bitn <= '0;
            end else begin
              rx_st <= R_IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        R_DATA: begin
          if (rx_tick) begin
            rx_cnt <= BIT_M1;
            if (rx_bitn == 3'd7) rx_st <= R_STOP;
            else rx_bitn <= rx_bitn + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        // Back to idle right at the stop sample so an immediate start bit is caught.
        R_STOP: begin
          if (rx_tick) begin
            rx_st <= R_IDLE;
            if (rx_s2) rx_vld <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        default: rx_st <= R_IDLE;
      endcase
    end
  end

  // rx_data holds the last byte until the next frame's first data sample,
  // well after the parser has consumed it.
  always_ff @(posedge CLK) begin
    if (rx_st == R_DATA && rx_tick) rx_data <= {rx_s2, rx_data[7:1]};
  end

  // ---- Parser: decode one received byte per rx_vld
  always_comb begin
    p_nxt   = p_st;
    wr_en   = 1'b0;
    rep_ok  = 1'b0;
    rep_err = 1'b0;
    wr_val  = {hi_nib, hex_val(rx_data)};
    rep_chr = chan_chr(ch_sel);
    rep_val = wr_val;
    if (rx_vld) begin
      case (p_st)
        P_IDLE: begin
          if (rx_data == ASC_S) p_nxt = P_CH;
`ifdef READBACK_EN
          else if (rx_data == ASC_R) p_nxt = P_RD;
`endif
        end
        P_CH: begin
          if (is_chan(rx_data)) begin
            p_nxt = P_HI;
          end else begin
            p_nxt   = P_IDLE;
            rep_err = 1'b1;
          end
        end
        P_HI: begin
          if (is_hex(rx_data)) begin
            p_nxt = P_LO;
          end else begin
            p_nxt   = P_IDLE;
            rep_err = 1'b1;
          end
        end
        P_LO: begin
          p_nxt = P_IDLE;
          if (is_hex(rx_data)) begin
            wr_en  = 1'b1;
            rep_ok = 1'b1;
          end else begin
            rep_err = 1'b1;
          end
        end
`ifdef READBACK_EN
        P_RD: begin
          p_nxt = P_IDLE;
          if (is_chan(rx_data)) begin
            rep_ok  = 1'b1;
            rep_chr = rx_data;
            rep_val = chreg[chan_idx(rx_data)];
          end else begin
            rep_err = 1'b1;
          end
        end
`endif
        default: p_nxt = P_IDLE;
      endcase
    end
  end

  // Replies requested while the transmitter is busy are dropped, not queued.
  assign rep_go = (rep_ok || rep_err) && !tx_busy;

  always_ff @(posedge CLK) begin
    if (RST) begin
      p_st    <= P_IDLE;
      rep_req <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) chreg[i] <= 8'h00;
    end else begin
      p_st    <= p_nxt;
      rep_req <= rep_go;
      if (wr_en) chreg[ch_sel] <= wr_val;
    end
  end

  always_ff @(posedge CLK) begin
    if (rx_vld && p_st == P_CH) ch_sel <= chan_idx(rx_data);
    if (rx_vld && p_st == P_HI) hi_nib <= hex_val(rx_data);
    if (rep_go) begin
      if (rep_ok) begin
        rep_b[0] <= ASC_S;
        rep_b[1] <= rep_chr;
        rep_b[2] <= hex_chr(rep_val[7:4]);
        rep_b[3] <= hex_chr(rep_val[3:0]);
        rep_b[4] <= ASC_CR;
        rep_b[5] <= ASC_LF;
        rep_len  <= 3'd6;
      end else begin
        rep_b[0] <= ASC_E;
        rep_b[1] <= ASC_CR;
        rep_b[2] <= ASC_LF;
        rep_len  <= 3'd3;
      end
    end
  end

  // ---- Transmitter: sends rep_b[0..rep_len-1] back to back, one stop bit each
  assign tx_last = (tx_idx == rep_len - 3'd1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      TX      <= 1'b1;
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_bitn <= '0;
      tx_idx  <= '0;
    end else if (!tx_busy) begin
      TX <= 1'b1;
      if (rep_req) begin
        tx_busy <= 1'b1;
        tx_idx  <= '0;
        tx_bitn <= '0;
        tx_cnt  <= BIT_M1;
        TX      <= 1'b0;
      end
    end else if (tx_cnt != '0) begin
      tx_cnt <= tx_cnt - 1'b1;
    end else begin
      tx_cnt <= BIT_M1;
      if (tx_bitn == 4'd9) begin
        if (tx_last) begin
          tx_busy <= 1'b0;
          TX      <= 1'b1;
        end else begin
          tx_idx  <= tx_idx + 3'd1;
          tx_bitn <= '0;
          TX      <= 1'b0;
        end
      end else begin
        tx_bitn <= tx_bitn + 4'd1;
        TX      <= tx_sh[1];
      end
    end
  end

  // tx_sh[0] always mirrors the bit currently on TX.
  always_ff @(posedge CLK) begin
    if (!tx_busy) begin
      if (rep_req) tx_sh <= frame(rep_b[0]);
    end else if (tx_cnt == '0) begin
      if (tx_bitn == 4'd9) begin
        if (!tx_last) tx_sh <= frame(rep_b[tx_idx + 3'd1]);
      end else begin
        tx_sh <= {1'b1, tx_sh[9:1]};
      end
    end
  end

endmodule

// File: tb/tb_uart_reg_cmd.sv
// Directed bench for uart_reg_cmd at 12 MHz / 115200 baud (104 clocks per bit).
// A free-running serial monitor decodes TX into a byte queue; each test task
// sends a command string on RX and compares the collected reply bytes.
module tb_uart_reg_cmd;

  localparam int BIT = 12000000 / 115200;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic RX  = 1'b1;
  logic TX;

  int ncmp  = 0;
  int nfail = 0;

  logic [7:0] rxq [$];

  uart_reg_cmd #(.CLK_HZ(12000000), .BAUD(115200), .NUM_CH(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .RX (RX),
    .TX (TX)
  );

  always #5 CLK = ~CLK;

  initial begin
    repeat (150000) @(posedge CLK);
    $display("FAIL watchdog: simulation exceeded 150000 cycles, want completion earlier");
    $fatal(1);
  end

  // TX monitor: start bit checked at half bit, then samples at bit centres.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge CLK);
      if (TX === 1'b0) begin
        repeat (BIT / 2) @(negedge CLK);
        if (TX === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge CLK);
            b[i] = TX;
          end
          repeat (BIT) @(negedge CLK);
          rxq.push_back(b);
        end
      end
    end
  end

  function automatic logic [7:0] qbyte(input int i);
    if (i < rxq.size()) return rxq[i];
    return 8'hxx;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    repeat (BIT) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BIT) @(negedge CLK);
    end
    RX = stop;
    repeat (BIT) @(negedge CLK);
    RX = 1'b1;
  endtask

  task automatic send_str(input string s);
    @(negedge CLK);
    for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]), 1'b1);
  endtask

  // Waits (bounded) for n bytes, then a little longer to catch surplus bytes.
  task automatic wait_q(input int n, output int got);
    int budget;
    budget = 20000;
    while (rxq.size() < n && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    repeat (2 * BIT) @(negedge CLK);
    got = rxq.size();
  endtask

  task automatic test_reset;
    int lows;
    RST = 1'b1;
    RX  = 1'b1;
    repeat (2) @(negedge CLK);
    ncmp++;
    if (TX !== 1'b1) begin
      nfail++;
      $display("FAIL reset_tx: got %b, want 1", TX);
    end
    repeat (2) @(negedge CLK);
    RST  = 1'b0;
    lows = 0;
    repeat (10 * BIT) begin
      @(negedge CLK);
      if (TX !== 1'b1) lows++;
    end
    ncmp++;
    if (lows !== 0) begin
      nfail++;
      $display("FAIL reset_idle: got %0d non-high cycles, want 0", lows);
    end
    rxq.delete();
  endtask

  task automatic test_write_ch0;
    string exp;
    int got;
    rxq.delete();
    send_str("S0F7");
    wait_q(6, got);
    exp = "S0F7\r\n";
    ncmp++;
    if (got !== exp.len()) begin
      nfail++;
      $display("FAIL ch0_len: got %0d bytes, want %0d", got, exp.len());
    end
    for (int i = 0; i < exp.len(); i++) begin
      ncmp++;
      if (qbyte(i) !== 8'(exp[i])) begin
        nfail++;
        $display("FAIL ch0_byte%0d: got 8'h%02h, want 8'h%02h", i, qbyte(i), 8'(exp[i]));
      end
    end
  endtask

  task automatic test_write_multi;
    string cmds [3];
    string exps [3];
    int got;
    cmds = '{"S259", "S114", "S350"};
    exps = '{"S259\r\n", "S114\r\n", "S350\r\n"};
    for (int c = 0; c < 3; c++) begin
      rxq.delete();
      send_str(cmds[c]);
      wait_q(6, got);
      ncmp++;
      if (got !== exps[c].len()) begin
        nfail++;
        $display("FAIL %s_len: got %0d bytes, want %0d", cmds[c], got, exps[c].len());
      end
      for (int i = 0; i < exps[c].len(); i++) begin
        ncmp++;
        if (qbyte(i) !== 8'(exps[c][i])) begin
          nfail++;
          $display("FAIL %s_byte%0d: got 8'h%02h, want 8'h%02h", cmds[c], i, qbyte(i), 8'(exps[c][i]));
        end
      end
    end
  endtask

  // "S4AA" errors at '4' (the "AA" falls into IDLE); "S0G1" errors at 'G'
  // and the trailing '1' is ignored.
  task automatic test_errors;
    string exp;
    int got;
    rxq.delete();
    send_str("S4AAS0G1");
    wait_q(6, got);
    exp = "E\r\nE\r\n";
    ncmp++;
    if (got !== exp.len()) begin
      nfail++;
      $display("FAIL err_len: got %0d bytes, want %0d", got, exp.len());
    end
    for (int i = 0; i < exp.len(); i++) begin
      ncmp++;
      if (qbyte(i) !== 8'(exp[i])) begin
        nfail++;
        $display("FAIL err_byte%0d: got 8'h%02h, want 8'h%02h", i, qbyte(i), 8'(exp[i]));
      end
    end
  endtask

  // Lowercase 's' is ignored; "S111" completes while the "S0AB" reply is
  // still being sent, so its reply is dropped.
  task automatic test_back_to_back;
    string exp;
    int got;
    rxq.delete();
    send_str("s0abS0abS111");
    wait_q(6, got);
    exp = "S0AB\r\n";
    ncmp++;
    if (got !== exp.len()) begin
      nfail++;
      $display("FAIL b2b_len: got %0d bytes, want %0d", got, exp.len());
    end
    for (int i = 0; i < exp.len(); i++) begin
      ncmp++;
      if (qbyte(i) !== 8'(exp[i])) begin
        nfail++;
        $display("FAIL b2b_byte%0d: got 8'h%02h, want 8'h%02h", i, qbyte(i), 8'(exp[i]));
      end
    end
`ifdef READBACK_EN
    rxq.delete();
    send_str("R1");
    wait_q(6, got);
    exp = "S111\r\n";
    ncmp++;
    if (got !== exp.len()) begin
      nfail++;
      $display("FAIL rd1_len: got %0d bytes, want %0d", got, exp.len());
    end
    for (int i = 0; i < exp.len(); i++) begin
      ncmp++;
      if (qbyte(i) !== 8'(exp[i])) begin
        nfail++;
        $display("FAIL rd1_byte%0d: got 8'h%02h, want 8'h%02h", i, qbyte(i), 8'(exp[i]));
      end
    end
`endif
  endtask

  task automatic test_framing;
    string exp;
    int got;
    rxq.delete();
    @(negedge CLK);
    send_byte(8'h53, 1'b0);
    repeat (12 * BIT) @(negedge CLK);
    send_str("S120");
    wait_q(6, got);
    exp = "S120\r\n";
    ncmp++;
    if (got !== exp.len()) begin
      nfail++;
      $display("FAIL frm_len: got %0d bytes, want %0d", got, exp.len());
    end
    for (int i = 0; i < exp.len(); i++) begin
      ncmp++;
      if (qbyte(i) !== 8'(exp[i])) begin
        nfail++;
        $display("FAIL frm_byte%0d: got 8'h%02h, want 8'h%02h", i, qbyte(i), 8'(exp[i]));
      end
    end
  endtask

  task automatic test_reset_mid;
    int budget;
    int lows;
    rxq.delete();
    send_str("S350");
    budget = 2000;
    while (TX !== 1'b0 && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    ncmp++;
    if (TX !== 1'b0) begin
      nfail++;
      $display("FAIL rstmid_busy: got TX=%b, want 0 (reply in progress)", TX);
    end
    RST = 1'b1;
    @(negedge CLK);
    ncmp++;
    if (TX !== 1'b1) begin
      nfail++;
      $display("FAIL rstmid_tx: got %b, want 1", TX);
    end
    repeat (2) @(negedge CLK);
    RST  = 1'b0;
    lows = 0;
    repeat (12 * BIT) begin
      @(negedge CLK);
      if (TX !== 1'b1) lows++;
    end
    ncmp++;
    if (lows !== 0) begin
      nfail++;
      $display("FAIL rstmid_idle: got %0d non-high cycles, want 0", lows);
    end
    rxq.delete();
`ifdef READBACK_EN
    begin
      string exp;
      int got;
      send_str("R1");
      wait_q(6, got);
      exp = "S100\r\n";
      ncmp++;
      if (got !== exp.len()) begin
        nfail++;
        $display("FAIL rstrd_len: got %0d bytes, want %0d", got, exp.len());
      end
      for (int i = 0; i < exp.len(); i++) begin
        ncmp++;
        if (qbyte(i) !== 8'(exp[i])) begin
          nfail++;
          $display("FAIL rstrd_byte%0d: got 8'h%02h, want 8'h%02h", i, qbyte(i), 8'(exp[i]));
        end
      end
    end
`endif
  endtask

  initial begin
    test_reset;
    test_write_ch0;
    test_write_multi;
    test_errors;
    test_back_to_back;
    test_framing;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
